// File: rtl/alu_seq.sv
// alu_seq: W-bit multi-cycle ALU with valid/ready handshake on both sides and a held {V,N,Z} status word.
// Build macro ALU_SEQ_MUL_EN adds the iterative shift-add multiplier; without it op 111 reports unsupported.
module alu_seq #(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] ain,
  input  logic [W-1:0] bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic [2:0]   status,
  output logic         busy,
  output logic [1:0]   o_state
);

  // Handshake: a transfer happens on either side only in a cycle where valid and ready are both high
  // at the rising edge; a source must hold its payload stable until that cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;

  state_t       r_state;
  state_t       w_next;
  logic         w_accept;
  logic         w_to_busy;
  logic         w_mul_done;
  logic [W-1:0] w_b_eff;
  logic [W-1:0] w_sum;
  logic [SHW-1:0] w_sh;
  logic [W-1:0] w_res;
  logic         w_v;

  assign w_accept = in_valid & in_ready;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [SHW:0] CNT_LAST = W[SHW:0];

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [SHW:0]   r_cnt;

  assign w_to_busy  = w_accept & (op == 3'b111);
  assign w_mul_done = (r_state == S_BUSY) & (r_cnt == CNT_LAST);

  // One shift-add step per cycle; after W steps r_acc holds the full product.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_to_busy) begin
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, ain};
      r_mplier <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_BUSY && r_cnt != CNT_LAST) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_to_busy  = 1'b0;
  assign w_mul_done = 1'b0;
`endif

  // Single-cycle datapath; SUB is ain + ~bin + 1 so op[0] doubles as the invert/carry-in select.
  always_comb begin
    w_b_eff = op[0] ? ~bin : bin;
    w_sum   = ain + w_b_eff + {{(W-1){1'b0}}, op[0]};
    w_sh    = bin[SHW-1:0];
    w_res   = '0;
    w_v     = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum;
        w_v   = (ain[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != ain[W-1]);
      end
      OP_AND: w_res = ain & bin;
      OP_NOT: w_res = ~bin;
      OP_LSL: w_res = ain << w_sh;
      OP_LSR: w_res = ain >> w_sh;
      OP_ASR: w_res = $signed(ain) >>> w_sh;
      default: begin
`ifdef ALU_SEQ_MUL_EN
        w_res = '0;
        w_v   = 1'b0;
`else
        w_res = '0;
        w_v   = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_to_busy ? S_BUSY : S_HOLD;
      S_BUSY: if (w_mul_done) w_next = S_HOLD;
      S_HOLD: begin
        if (w_accept)       w_next = w_to_busy ? S_BUSY : S_HOLD;
        else if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_HOLD);
    in_ready  = !reset && (r_state != S_BUSY) && (!out_valid || out_ready);
    o_state   = r_state;
`ifdef ALU_SEQ_MUL_EN
    busy      = (r_state == S_BUSY) && (r_cnt != '0);
`else
    busy      = 1'b0;
`endif
  end

  // out/status change only on commit, so status stays valid for branch logic after consumption.
  always_ff @(posedge clk) begin
    if (reset) begin
      out    <= '0;
      status <= 3'b000;
    end else if (w_accept && !w_to_busy) begin
      out    <= w_res;
      status <= {w_v, w_res[W-1], (w_res == '0)};
    end
`ifdef ALU_SEQ_MUL_EN
    else if (w_mul_done) begin
      out    <= r_acc[W-1:0];
      status <= {(r_acc[2*W-1:W] != '0), r_acc[W-1], (r_acc[W-1:0] == '0)};
    end
`endif
  end

endmodule
